// File: rtl/loop_control_if.sv
// Loop-control bundle between the fetch/decode side (master) and loop_control_unit (slave).
interface loop_control_if #(
  parameter int unsigned PC_WIDTH    = 16,
  parameter int unsigned STACK_DEPTH = 16
);
  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH) + 1;

  logic [PC_WIDTH-1:0] pc;
  logic                is_open;
  logic                is_close;
  logic                cell_zero;
  logic                stall;
  logic                pc_src;
  logic                pc_write;
  logic [PC_WIDTH-1:0] pc_loaded;
  logic                squash;
  logic                fault;
  logic [DEPTH_W-1:0]  depth;

  modport master (
    output pc, is_open, is_close, cell_zero, stall,
    input  pc_src, pc_write, pc_loaded, squash, fault, depth
  );

  modport slave (
    input  pc, is_open, is_close, cell_zero, stall,
    output pc_src, pc_write, pc_loaded, squash, fault, depth
  );
endinterface

// File: rtl/loop_control_unit.sv
// Bracket sequencer: loop-start return stack, nested forward skip on '[' over a zero cell,
// and PC source/write control for fetch_unit.
module loop_control_unit #(
  parameter int unsigned PC_WIDTH       = 16,
  parameter int unsigned STACK_DEPTH    = 16,
  parameter int unsigned SKIP_CNT_WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  loop_control_if.slave lc
);
  localparam int unsigned SP_W  = $clog2(STACK_DEPTH) + 1;
  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);

  localparam logic PC_INCREMENTED = 1'b0;
  localparam logic PC_LOADED      = 1'b1;
  localparam logic ENABLE         = 1'b1;
  localparam logic DISABLE        = 1'b0;

  typedef enum logic [1:0] {RUN, SKIP, FAULT} state_e;

  state_e                    state_q, state_d;
  logic [SP_W-1:0]           sp_q, sp_d;
  logic [SKIP_CNT_WIDTH-1:0] skip_cnt_q, skip_cnt_d;
  logic [PC_WIDTH-1:0]       stack_q [STACK_DEPTH];
  logic                      push;
  logic                      stack_empty;
  logic                      stack_full;
  logic [IDX_W-1:0]          top_idx;

  assign stack_empty  = (sp_q == '0);
  assign stack_full   = (sp_q == SP_W'(STACK_DEPTH));
  assign top_idx      = IDX_W'(sp_q - SP_W'(1));
  assign lc.pc_loaded = stack_empty ? '0 : stack_q[top_idx];
  assign lc.depth     = reset ? '0 : sp_q;

  // Next state and per-instruction control; stall holds all state but keeps outputs live.
  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    skip_cnt_d  = skip_cnt_q;
    push        = 1'b0;
    lc.pc_src   = PC_INCREMENTED;
    lc.pc_write = ENABLE;
    lc.squash   = 1'b0;
    lc.fault    = 1'b0;

    if (reset) begin
      state_d     = RUN;
      sp_d        = '0;
      skip_cnt_d  = '0;
      lc.pc_write = DISABLE;
      lc.squash   = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (lc.is_open && lc.is_close) begin
            state_d     = FAULT;
            lc.pc_write = DISABLE;
          end else if (lc.is_open) begin
            if (lc.cell_zero) begin
              state_d    = SKIP;
              skip_cnt_d = '0;
            end else if (stack_full) begin
              state_d = FAULT;
            end else begin
              push = 1'b1;
              sp_d = sp_q + SP_W'(1);
            end
          end else if (lc.is_close) begin
            if (stack_empty) begin
              state_d     = FAULT;
              lc.pc_write = DISABLE;
            end else if (!lc.cell_zero) begin
              lc.pc_src = PC_LOADED;
            end else begin
              sp_d = sp_q - SP_W'(1);
            end
          end
        end
        SKIP: begin
          lc.squash = 1'b1;
          if (lc.is_open && lc.is_close) begin
            state_d = FAULT;
          end else if (lc.is_open) begin
            if (&skip_cnt_q) state_d = FAULT;
            else             skip_cnt_d = skip_cnt_q + SKIP_CNT_WIDTH'(1);
          end else if (lc.is_close) begin
            if (skip_cnt_q == '0) state_d = RUN;
            else                  skip_cnt_d = skip_cnt_q - SKIP_CNT_WIDTH'(1);
          end
        end
        FAULT: begin
          lc.pc_write = DISABLE;
          lc.squash   = 1'b1;
          lc.fault    = 1'b1;
        end
        default: begin
          state_d = FAULT;
        end
      endcase

      if (lc.stall && (state_q != FAULT)) begin
        state_d     = state_q;
        sp_d        = sp_q;
        skip_cnt_d  = skip_cnt_q;
        push        = 1'b0;
        lc.pc_write = DISABLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      sp_q       <= '0;
      skip_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  // Return address of a loop is the instruction after its '['.
  always_ff @(posedge clk) begin
    if (push) stack_q[sp_q[IDX_W-1:0]] <= lc.pc + PC_WIDTH'(1);
  end
endmodule

// File: tb/tb_loop_control_unit.sv
// Directed bench for loop_control_unit: per-cycle comparison against a queue-based bracket model
// plus literal expectations taken from hand-worked scenarios.
module tb_loop_control_unit;
  localparam int M_RUN   = 0;
  localparam int M_SKIP  = 1;
  localparam int M_FAULT = 2;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  loop_control_if #(.PC_WIDTH(16), .STACK_DEPTH(16)) lc();

  loop_control_unit #(
    .PC_WIDTH(16), .STACK_DEPTH(16), .SKIP_CNT_WIDTH(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .lc    (lc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bracket model: stack of return addresses, mode, and nesting depth inside a skip.
  logic [15:0] stk[$];
  int          mode;
  int          nest;

  initial begin
    logic [15:0] top;
    logic        e_src, e_write, e_sq, e_f, illegal;
    mode = M_RUN;
    nest = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_pc_write", 32'(lc.pc_write), 32'd0);
        chk("rst_pc_src",   32'(lc.pc_src),   32'd0);
        chk("rst_squash",   32'(lc.squash),   32'd1);
        chk("rst_fault",    32'(lc.fault),    32'd0);
        chk("rst_depth",    32'(lc.depth),    32'd0);
        stk.delete();
        mode = M_RUN;
        nest = 0;
      end else begin
        top     = (stk.size() > 0) ? stk[$] : 16'h0000;
        illegal = (lc.is_open && lc.is_close) || (lc.is_close && !lc.is_open && stk.size() == 0);
        e_src = 1'b0; e_write = 1'b1; e_sq = 1'b0; e_f = 1'b0;
        if (mode == M_FAULT) begin
          e_write = 1'b0; e_sq = 1'b1; e_f = 1'b1;
        end else if (mode == M_SKIP) begin
          e_sq = 1'b1; e_write = !lc.stall;
        end else begin
          e_write = !lc.stall && !illegal;
          e_src   = lc.is_close && !lc.is_open && !lc.cell_zero && stk.size() > 0;
        end
        chk("pc_src",    32'(lc.pc_src),    32'(e_src));
        chk("pc_write",  32'(lc.pc_write),  32'(e_write));
        chk("squash",    32'(lc.squash),    32'(e_sq));
        chk("fault",     32'(lc.fault),     32'(e_f));
        chk("pc_loaded", 32'(lc.pc_loaded), 32'(top));
        chk("depth",     32'(lc.depth),     32'(stk.size()));
        if (!lc.stall && mode == M_SKIP) begin
          if (lc.is_open && lc.is_close) mode = M_FAULT;
          else if (lc.is_open) begin
            if (nest == 255) mode = M_FAULT;
            else nest++;
          end else if (lc.is_close) begin
            if (nest == 0) mode = M_RUN;
            else nest--;
          end
        end else if (!lc.stall && mode == M_RUN) begin
          if (illegal) mode = M_FAULT;
          else if (lc.is_open) begin
            if (lc.cell_zero) begin
              mode = M_SKIP;
              nest = 0;
            end else if (stk.size() == 16) mode = M_FAULT;
            else stk.push_back(lc.pc + 16'd1);
          end else if (lc.is_close && lc.cell_zero) begin
            void'(stk.pop_back());
          end
        end
      end
    end
  end

  // One instruction cycle: inputs change just after the rising edge; returns at the falling edge.
  task automatic cyc(input logic r, input logic [15:0] p, input logic o, input logic c,
                     input logic z, input logic s);
    @(posedge clk);
    #1;
    reset        = r;
    lc.pc        = p;
    lc.is_open   = o;
    lc.is_close  = c;
    lc.cell_zero = z;
    lc.stall     = s;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    lc.pc = 16'h0000; lc.is_open = 1'b0; lc.is_close = 1'b0;
    lc.cell_zero = 1'b0; lc.stall = 1'b0;

    // Reset and release
    cyc(1, 16'h0000, 0, 0, 0, 0);
    cyc(1, 16'h0000, 0, 0, 0, 0);
    chk("lit_rst_write", 32'(lc.pc_write), 32'd0);
    chk("lit_rst_squash", 32'(lc.squash), 32'd1);
    cyc(0, 16'h0000, 0, 0, 0, 0);
    chk("lit_run_write", 32'(lc.pc_write), 32'd1);
    chk("lit_run_squash", 32'(lc.squash), 32'd0);

    // Basic loop
    cyc(0, 16'h0010, 1, 0, 0, 0);
    cyc(0, 16'h0011, 0, 0, 0, 0);
    chk("lit_loop_depth1", 32'(lc.depth), 32'd1);
    cyc(0, 16'h0014, 0, 1, 0, 0);
    chk("lit_loop_src", 32'(lc.pc_src), 32'd1);
    chk("lit_loop_target", 32'(lc.pc_loaded), 32'h0011);
    cyc(0, 16'h0014, 0, 1, 1, 0);
    chk("lit_exit_src", 32'(lc.pc_src), 32'd0);
    cyc(0, 16'h0015, 0, 0, 0, 0);
    chk("lit_exit_depth", 32'(lc.depth), 32'd0);

    // Skip with nesting, including a stalled cycle inside the skip
    cyc(0, 16'h0020, 1, 0, 1, 0);
    chk("lit_skip_open_squash", 32'(lc.squash), 32'd0);
    cyc(0, 16'h0021, 1, 0, 0, 0);
    chk("lit_skip_sq1", 32'(lc.squash), 32'd1);
    cyc(0, 16'h0022, 1, 0, 1, 1);
    chk("lit_skip_stall_write", 32'(lc.pc_write), 32'd0);
    cyc(0, 16'h0022, 1, 0, 1, 0);
    cyc(0, 16'h0023, 0, 1, 0, 0);
    cyc(0, 16'h0024, 0, 1, 1, 0);
    cyc(0, 16'h0025, 0, 1, 0, 0);
    chk("lit_skip_last_squash", 32'(lc.squash), 32'd1);
    chk("lit_skip_last_src", 32'(lc.pc_src), 32'd0);
    cyc(0, 16'h0026, 0, 0, 0, 0);
    chk("lit_after_skip_squash", 32'(lc.squash), 32'd0);
    chk("lit_after_skip_depth", 32'(lc.depth), 32'd0);

    // Stall on a taken backward jump
    cyc(0, 16'h0030, 1, 0, 0, 0);
    repeat (3) begin
      cyc(0, 16'h0040, 0, 1, 0, 1);
      chk("lit_stall_write", 32'(lc.pc_write), 32'd0);
      chk("lit_stall_depth", 32'(lc.depth), 32'd1);
    end
    cyc(0, 16'h0040, 0, 1, 0, 0);
    chk("lit_unstall_write", 32'(lc.pc_write), 32'd1);
    chk("lit_unstall_src", 32'(lc.pc_src), 32'd1);
    chk("lit_unstall_target", 32'(lc.pc_loaded), 32'h0031);
    cyc(0, 16'h0040, 0, 1, 1, 0);

    // Overflow with PC wrap on the first push
    cyc(1, 16'h0000, 0, 0, 0, 0);
    cyc(0, 16'hFFFF, 1, 0, 0, 0);
    cyc(0, 16'h0100, 0, 0, 0, 0);
    chk("lit_wrap_bottom", 32'(lc.pc_loaded), 32'h0000);
    for (int i = 1; i < 16; i++) cyc(0, 16'(16'h0100 + i), 1, 0, 0, 0);
    cyc(0, 16'h0200, 0, 0, 0, 0);
    chk("lit_full_depth", 32'(lc.depth), 32'd16);
    cyc(0, 16'h0201, 1, 0, 0, 0);
    chk("lit_ovf_fault_pre", 32'(lc.fault), 32'd0);
    cyc(0, 16'h0202, 0, 0, 0, 0);
    chk("lit_ovf_fault", 32'(lc.fault), 32'd1);
    chk("lit_ovf_write", 32'(lc.pc_write), 32'd0);
    repeat (3) cyc(0, 16'h0203, 0, 1, 1, 0);
    chk("lit_ovf_sticky", 32'(lc.fault), 32'd1);
    chk("lit_ovf_frozen_depth", 32'(lc.depth), 32'd16);

    // Underflow with cell_zero=0, then cell_zero=1, then both strobes together
    cyc(1, 16'h0000, 0, 0, 0, 0);
    cyc(0, 16'h0300, 0, 1, 0, 0);
    chk("lit_unf0_write", 32'(lc.pc_write), 32'd0);
    cyc(0, 16'h0301, 0, 0, 0, 0);
    chk("lit_unf0_fault", 32'(lc.fault), 32'd1);
    cyc(1, 16'h0000, 0, 0, 0, 0);
    cyc(0, 16'h0310, 0, 1, 1, 0);
    cyc(0, 16'h0311, 0, 0, 0, 0);
    chk("lit_unf1_fault", 32'(lc.fault), 32'd1);
    cyc(1, 16'h0000, 0, 0, 0, 0);
    cyc(0, 16'h0320, 1, 1, 0, 0);
    cyc(0, 16'h0321, 0, 0, 0, 0);
    chk("lit_both_fault", 32'(lc.fault), 32'd1);

    // Skip nesting counter saturation: 255 nested '[' are fine, the 256th faults
    cyc(1, 16'h0000, 0, 0, 0, 0);
    cyc(0, 16'h0400, 1, 0, 1, 0);
    for (int i = 0; i < 255; i++) cyc(0, 16'(16'h0401 + i), 1, 0, 0, 0);
    cyc(0, 16'h0600, 0, 0, 0, 0);
    chk("lit_nest_ok", 32'(lc.fault), 32'd0);
    cyc(0, 16'h0601, 1, 0, 0, 0);
    cyc(0, 16'h0602, 0, 0, 0, 0);
    chk("lit_nest_fault", 32'(lc.fault), 32'd1);

    cyc(1, 16'h0000, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
